// File: rtl/jpeg_stream_loader_if.sv
// ----------------------------------------------------------------------------
// jpeg_stream_loader_if
//   Byte stream from the JPEG stream loader to the decoder front end.
//   Signals:
//     byte_data  [7:0]  FIFO head byte
//     byte_sof          head byte is the FF of SOI
//     byte_eof          head byte is the D9 of EOI
//     byte_valid        FIFO not empty
//     byte_ready        consumer accepts head when byte_valid & byte_ready
//   Modports: master (loader side), slave (consumer side).
// ----------------------------------------------------------------------------
interface jpeg_stream_loader_if;
    logic [7:0] byte_data;
    logic       byte_sof;
    logic       byte_eof;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_sof,
        output byte_eof,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_sof,
        input  byte_eof,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/jpeg_stream_loader.sv
// ----------------------------------------------------------------------------
// jpeg_stream_loader
//   Packs the UART receiver's bit stream LSB-first into bytes, hunts for SOI
//   (FF D8) and forwards every byte from SOI through EOI (FF D9) inclusive
//   into a first-word-fall-through output FIFO.
//   Ports:
//     clk            system clock, rising edge
//     rst            asynchronous active-low reset
//     i_bit_in       data bit from the UART receiver
//     i_is_new       1-cycle strobe, i_bit_in valid (8 per byte, LSB first)
//     i_start        arm pulse (IDLE/DONE/ERROR -> HUNT), clears errors/count
//     o_stream       byte stream (master modport of jpeg_stream_loader_if)
//     o_busy         HUNT, SOI pending, STREAM or DRAIN
//     o_done         1-cycle pulse on DRAIN -> DONE
//     o_err_ovf      sticky, byte dropped on full FIFO
//     o_err_tmo      sticky, no completed byte for IDLE_TIMEOUT cycles
//     o_byte_count   bytes pushed this image, saturating
// ----------------------------------------------------------------------------
module jpeg_stream_loader #(
    parameter int FIFO_DEPTH   = 16,
    parameter int IDLE_TIMEOUT = 1_000_000,
    parameter int GAP_CYCLES   = 20_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_bit_in,
    input  logic                        i_is_new,
    input  logic                        i_start,
    jpeg_stream_loader_if.master        o_stream,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err_ovf,
    output logic                        o_err_tmo,
    output logic [23:0]                 o_byte_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HUNT, S_PEND, S_STREAM, S_DRAIN, S_DONE, S_ERROR
    } state_t;

    // ---------------- byte assembler ----------------
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [GW-1:0] r_gap_cnt;
    logic          r_byte_done;
    logic          r_prev_ff;

    // The completed byte is simply the shift register during the byte_done
    // cycle; the next strobe cannot arrive before that cycle has ended.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_gap_cnt   <= '0;
            r_byte_done <= 1'b0;
            r_prev_ff   <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            if (i_is_new) begin
                r_gap_cnt          <= '0;
                r_shift[r_bit_cnt] <= i_bit_in;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7)
                    r_byte_done <= 1'b1;
            end else if (r_bit_cnt != 3'd0) begin
                // Lost strobes mid-byte: drop the partial byte and realign.
                if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    r_bit_cnt <= '0;
                    r_gap_cnt <= '0;
                end else begin
                    r_gap_cnt <= r_gap_cnt + GW'(1);
                end
            end
            if (r_byte_done)
                r_prev_ff <= (r_shift == 8'hFF);
        end
    end

    // ---------------- FIFO status / push arbitration ----------------
    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop, w_full, w_push_ok, w_ovf;

    state_t        r_state, w_state_next, w_state_fin;
    logic          w_push_req, w_push_sof, w_push_eof;
    logic [7:0]    w_push_data;
    logic          w_start_ok, w_done_next, w_tmo_hit;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_done, r_err_ovf, r_err_tmo;
    logic [23:0]   r_byte_count;

    assign w_pop     = (r_count != '0) && o_stream.byte_ready;
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push_ok = w_push_req && (!w_full || w_pop);
    assign w_ovf     = w_push_req && !w_push_ok;
    assign w_state_fin = w_ovf ? S_ERROR : w_state_next;

    // ---------------- FSM next state / push request ----------------
    always_comb begin
        w_state_next = r_state;
        w_push_req   = 1'b0;
        w_push_data  = r_shift;
        w_push_sof   = 1'b0;
        w_push_eof   = 1'b0;
        w_start_ok   = 1'b0;
        w_done_next  = 1'b0;
        w_tmo_hit    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_start_ok   = 1'b1;
                    w_state_next = S_HUNT;
                end
            end
            S_HUNT: begin
                if (r_byte_done && r_prev_ff && (r_shift == 8'hD8)) begin
                    w_push_req   = 1'b1;
                    w_push_data  = 8'hFF;
                    w_push_sof   = 1'b1;
                    w_state_next = S_PEND;
                end
            end
            S_PEND: begin
                // Second half of SOI, pushed the cycle after the FF.
                w_push_req   = 1'b1;
                w_push_data  = 8'hD8;
                w_state_next = S_STREAM;
            end
            S_STREAM: begin
                if (r_byte_done) begin
                    w_push_req = 1'b1;
                    if (r_prev_ff && (r_shift == 8'hD9)) begin
                        w_push_eof   = 1'b1;
                        w_state_next = S_DRAIN;
                    end
                end else if (r_tmo_cnt == TW'(IDLE_TIMEOUT - 1)) begin
                    w_tmo_hit    = 1'b1;
                    w_state_next = S_ERROR;
                end
            end
            S_DRAIN: begin
                if (r_count == '0) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM state and status registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_tmo    <= 1'b0;
            r_byte_count <= '0;
            r_tmo_cnt    <= '0;
        end else begin
            r_state <= w_state_fin;
            r_done  <= w_done_next;
            if (w_start_ok) begin
                r_err_ovf    <= 1'b0;
                r_err_tmo    <= 1'b0;
                r_byte_count <= '0;
            end else begin
                if (w_ovf)
                    r_err_ovf <= 1'b1;
                if (w_tmo_hit)
                    r_err_tmo <= 1'b1;
                if (w_push_ok && (r_byte_count != 24'hFFFFFF))
                    r_byte_count <= r_byte_count + 24'd1;
            end
            if ((r_state != S_STREAM) || r_byte_done)
                r_tmo_cnt <= '0;
            else
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end

    // ---------------- FIFO storage and pointers ----------------
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= {w_push_sof, w_push_eof, w_push_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_start_ok) begin
            // Arming always starts from an empty FIFO (flushes after ERROR).
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- outputs ----------------
    logic [9:0] w_head;
    assign w_head = r_mem[r_rd_ptr];

    // Head is masked while empty so outputs are 0 out of reset.
    assign o_stream.byte_valid = (r_count != '0);
    assign o_stream.byte_data  = o_stream.byte_valid ? w_head[7:0] : 8'h00;
    assign o_stream.byte_eof   = o_stream.byte_valid ? w_head[8]   : 1'b0;
    assign o_stream.byte_sof   = o_stream.byte_valid ? w_head[9]   : 1'b0;

    assign o_busy       = (r_state == S_HUNT) || (r_state == S_PEND) ||
                          (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign o_done       = r_done;
    assign o_err_ovf    = r_err_ovf;
    assign o_err_tmo    = r_err_tmo;
    assign o_byte_count = r_byte_count;
endmodule

// File: tb/tb_jpeg_stream_loader.sv
// ----------------------------------------------------------------------------
// tb_jpeg_stream_loader
//   Self-checking bench: expected FIFO entries {sof,eof,data} are queued as
//   bytes are sent; a monitor records every popped entry and each scenario
//   task compares the recorded pops against its expectations.
// ----------------------------------------------------------------------------
module tb_jpeg_stream_loader;
    localparam int DEPTH = 16;
    localparam int TMO   = 300;
    localparam int GAP   = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_in = 1'b0;
    logic        is_new = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err_ovf, err_tmo;
    logic [23:0] byte_count;

    jpeg_stream_loader_if bus_if ();

    jpeg_stream_loader #(
        .FIFO_DEPTH  (DEPTH),
        .IDLE_TIMEOUT(TMO),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_bit_in    (bit_in),
        .i_is_new    (is_new),
        .i_start     (start),
        .o_stream    (bus_if),
        .o_busy      (busy),
        .o_done      (done),
        .o_err_ovf   (err_ovf),
        .o_err_tmo   (err_tmo),
        .o_byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;
    logic [9:0] exp_q [$];
    logic [9:0] got_q [$];
    logic [9:0] mon_got;

    // Sample away from the rising edge; a pop happens at the next edge.
    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (bus_if.byte_valid && bus_if.byte_ready) begin
            mon_got = {bus_if.byte_sof, bus_if.byte_eof, bus_if.byte_data};
            got_q.push_back(mon_got);
            $display("pop: data=%h sof=%0b eof=%0b", mon_got[7:0], mon_got[9], mon_got[8]);
        end
    end

    function automatic logic [9:0] ent(input logic sof, input logic eof, input logic [7:0] d);
        return {sof, eof, d};
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1;
        is_new = 1'b1;
        bit_in = b;
        @(posedge clk);
        #1;
        is_new = 1'b0;
    endtask

    // pulse_rdy raises byte_ready only in the cycle the byte is pushed.
    task automatic send_byte(input logic [7:0] b, input logic pulse_rdy);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (pulse_rdy) bus_if.byte_ready = 1'b1;
        @(posedge clk);
        #1;
        if (pulse_rdy) bus_if.byte_ready = 1'b0;
        @(posedge clk);
        #1;
        $display("sent byte %h", b);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done_wait got=no done pulse required=done within 2000 cycles", name);
        end
    endtask

    task automatic test_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, err_ovf, err_tmo, byte_count, bus_if.byte_valid,
             bus_if.byte_data, bus_if.byte_sof, bus_if.byte_eof} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_in_reset got busy=%b valid=%b cnt=%h required all 0",
                     busy, bus_if.byte_valid, byte_count);
        end
        wait_cycles(2);
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(1);
        checks++;
        if ({busy, done, err_ovf, err_tmo, byte_count, bus_if.byte_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_after got busy=%b valid=%b cnt=%h required all 0",
                     busy, bus_if.byte_valid, byte_count);
        end
        send_byte(8'h33, 1'b0);
        wait_cycles(4);
        checks++;
        if (busy !== 1'b0 || bus_if.byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_byte got busy=%b valid=%b required 0/0", busy, bus_if.byte_valid);
        end
        $display("test_reset complete");
    endtask

    task automatic test_stream();
        logic [7:0] seq [6];
        logic [9:0] g, e;
        int d0, n;
        seq = '{8'h12, 8'hFF, 8'hD8, 8'hAA, 8'hFF, 8'hD9};
        bus_if.byte_ready = 1'b1;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL stream_busy_hunt got=%b required=1", busy);
        end
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            // Every byte from the SOI FF onward is forwarded; 12 is hunted over.
            if (i >= 1) exp_q.push_back(ent(i == 1, i == 5, seq[i]));
            send_byte(seq[i], 1'b0);
        end
        wait_done(d0, "stream");
        wait_cycles(5);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL stream_done_pulses got=%0d required=1", done_cnt - d0);
        end
        checks++;
        if (byte_count !== 24'd5) begin
            errors++;
            $display("FAIL stream_byte_count got=%0d required=5", byte_count);
        end
        n = exp_q.size();
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL stream_pop_count got=%0d required=%0d", got_q.size(), n);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL stream_entry got=%h required=%h", g, e);
            end
        end
        got_q.delete();
        exp_q.delete();
        $display("test_stream complete");
    endtask

    task automatic test_overflow();
        logic [9:0] g, e;
        int n;
        bus_if.byte_ready = 1'b0;
        pulse_start();
        exp_q.push_back(ent(1'b1, 1'b0, 8'hFF));
        send_byte(8'hFF, 1'b0);
        exp_q.push_back(ent(1'b0, 1'b0, 8'hD8));
        send_byte(8'hD8, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            if (i <= DEPTH - 2) exp_q.push_back(ent(1'b0, 1'b0, 8'(i)));
            send_byte(8'(i), 1'b0);
        end
        checks++;
        if (err_ovf !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flag got ovf=%b busy=%b required ovf=1 busy=0", err_ovf, busy);
        end
        checks++;
        if (byte_count !== 24'd16) begin
            errors++;
            $display("FAIL ovf_byte_count got=%0d required=16", byte_count);
        end
        bus_if.byte_ready = 1'b1;
        wait_cycles(30);
        bus_if.byte_ready = 1'b0;
        n = exp_q.size();
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL ovf_pop_count got=%0d required=%0d", got_q.size(), n);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL ovf_entry got=%h required=%h", g, e);
            end
        end
        got_q.delete();
        exp_q.delete();
        $display("test_overflow complete");
    endtask

    task automatic test_timeout();
        logic [9:0] g, e;
        int n;
        bus_if.byte_ready = 1'b1;
        pulse_start();
        checks++;
        if (err_ovf !== 1'b0 || busy !== 1'b1 || bus_if.byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_restart got ovf=%b busy=%b valid=%b required 0/1/0",
                     err_ovf, busy, bus_if.byte_valid);
        end
        exp_q.push_back(ent(1'b1, 1'b0, 8'hFF));
        send_byte(8'hFF, 1'b0);
        exp_q.push_back(ent(1'b0, 1'b0, 8'hD8));
        send_byte(8'hD8, 1'b0);
        n = 0;
        while (err_tmo !== 1'b1 && n < TMO + 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (err_tmo !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_flag got tmo=%b busy=%b required tmo=1 busy=0", err_tmo, busy);
        end
        checks++;
        if (n < TMO - 2 || n > TMO + 2) begin
            errors++;
            $display("FAIL tmo_latency got=%0d required=%0d+-2 cycles", n, TMO);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL tmo_entry got=%h required=%h", g, e);
            end
        end
        checks++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL tmo_pop_count got left exp=%0d got=%0d required 0/0", exp_q.size(), got_q.size());
        end
        got_q.delete();
        exp_q.delete();
        pulse_start();
        checks++;
        if (err_tmo !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_clear got tmo=%b busy=%b required tmo=0 busy=1", err_tmo, busy);
        end
        $display("test_timeout complete");
    endtask

    // Loader is left in HUNT by test_timeout.
    task automatic test_resync();
        logic [9:0] g, e;
        int d0, n;
        bus_if.byte_ready = 1'b1;
        d0 = done_cnt;
        exp_q.push_back(ent(1'b1, 1'b0, 8'hFF));
        send_byte(8'hFF, 1'b0);
        exp_q.push_back(ent(1'b0, 1'b0, 8'hD8));
        send_byte(8'hD8, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        wait_cycles(GAP + 10);
        exp_q.push_back(ent(1'b0, 1'b0, 8'h5A));
        send_byte(8'h5A, 1'b0);
        exp_q.push_back(ent(1'b0, 1'b0, 8'hFF));
        send_byte(8'hFF, 1'b0);
        exp_q.push_back(ent(1'b0, 1'b1, 8'hD9));
        send_byte(8'hD9, 1'b0);
        wait_done(d0, "resync");
        wait_cycles(3);
        checks++;
        if (byte_count !== 24'd5) begin
            errors++;
            $display("FAIL resync_byte_count got=%0d required=5", byte_count);
        end
        n = exp_q.size();
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL resync_pop_count got=%0d required=%0d", got_q.size(), n);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL resync_entry got=%h required=%h", g, e);
            end
        end
        got_q.delete();
        exp_q.delete();
        $display("test_resync complete");
    endtask

    task automatic test_full_pop();
        logic [9:0] g, e;
        int d0, n;
        bus_if.byte_ready = 1'b0;
        pulse_start();
        d0 = done_cnt;
        exp_q.push_back(ent(1'b1, 1'b0, 8'hFF));
        send_byte(8'hFF, 1'b0);
        exp_q.push_back(ent(1'b0, 1'b0, 8'hD8));
        send_byte(8'hD8, 1'b0);
        for (int i = 0; i < DEPTH - 2; i++) begin
            exp_q.push_back(ent(1'b0, 1'b0, 8'h21 + 8'(i)));
            send_byte(8'h21 + 8'(i), 1'b0);
        end
        // FIFO is full here; the next byte lands in the same cycle as a pop.
        exp_q.push_back(ent(1'b0, 1'b0, 8'h2F));
        send_byte(8'h2F, 1'b1);
        checks++;
        if (err_ovf !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_flags got ovf=%b busy=%b required ovf=0 busy=1", err_ovf, busy);
        end
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL full_pop_single got=%0d pops required=1", got_q.size());
        end
        bus_if.byte_ready = 1'b1;
        wait_cycles(30);
        checks++;
        if (got_q.size() != DEPTH + 1) begin
            errors++;
            $display("FAIL full_pop_total got=%0d pops required=%0d", got_q.size(), DEPTH + 1);
        end
        exp_q.push_back(ent(1'b0, 1'b0, 8'hFF));
        send_byte(8'hFF, 1'b0);
        exp_q.push_back(ent(1'b0, 1'b1, 8'hD9));
        send_byte(8'hD9, 1'b0);
        wait_done(d0, "full_pop");
        wait_cycles(3);
        checks++;
        if (byte_count !== 24'd19 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_count got cnt=%0d ovf=%b required cnt=19 ovf=0", byte_count, err_ovf);
        end
        n = exp_q.size();
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL full_pop_pop_count got=%0d required=%0d", got_q.size(), n);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL full_pop_entry got=%h required=%h", g, e);
            end
        end
        got_q.delete();
        exp_q.delete();
        $display("test_full_pop complete");
    endtask

    initial begin
        bus_if.byte_ready = 1'b0;
        wait_cycles(3);
        @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_stream();
        test_overflow();
        test_timeout();
        test_resync();
        test_full_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=simulation still running required=finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
